// File: rtl/scoreboard_register_file.sv
// Register file with two combinational read ports, two clocked write ports
// (A: single-cycle ALU results, B: long-latency writeback), write-first
// bypass on both reads and a per-register busy scoreboard with a running
// count of pending registers for the issue logic.
module scoreboard_register_file #(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 3,
  parameter bit ZeroReg   = 1'b0
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [AddrWidth-1:0] RS,
  input  logic [AddrWidth-1:0] RT,
  output logic [DataWidth-1:0] ReadRS,
  output logic [DataWidth-1:0] ReadRT,
  output logic                 ReadyRS,
  output logic                 ReadyRT,
  input  logic [AddrWidth-1:0] RDA,
  input  logic [DataWidth-1:0] WriteDataA,
  input  logic                 RegWriteA,
  input  logic [AddrWidth-1:0] RDB,
  input  logic [DataWidth-1:0] WriteDataB,
  input  logic                 RegWriteB,
  input  logic                 SetBusy,
  input  logic [AddrWidth-1:0] BusyAddr,
  output logic [AddrWidth:0]   BusyCount
);

  localparam int Depth      = 1 << AddrWidth;
  localparam int CountWidth = AddrWidth + 1;

  logic [DataWidth-1:0]  regs [Depth];
  logic [Depth-1:0]      busy;
  logic [Depth-1:0]      busyNext;
  logic [CountWidth-1:0] busyCount;
  logic [CountWidth-1:0] countNext;

  logic rdaIsZero;
  logic rdbIsZero;
  logic busyAddrIsZero;
  logic writeEnA;
  logic writeEnB;
  logic setEn;
  logic countInc;
  logic countDec;

  logic rsIsZero;
  logic rtIsZero;
  logic rsHitA;
  logic rsHitB;
  logic rtHitA;
  logic rtHitB;

  // With a hardwired zero register, any write or busy request aimed at
  // address 0 is swallowed here so storage and scoreboard never see it.
  assign rdaIsZero      = ZeroReg && (RDA == '0);
  assign rdbIsZero      = ZeroReg && (RDB == '0);
  assign busyAddrIsZero = ZeroReg && (BusyAddr == '0);

  assign writeEnA = RegWriteA && !rdaIsZero;
  assign writeEnB = RegWriteB && !rdbIsZero;
  assign setEn    = SetBusy && !busyAddrIsZero;

  // The count moves only on real busy transitions: a set on an idle
  // register adds one, a clear on a busy register removes one unless the
  // same register is reissued in this cycle (set wins, net stays busy).
  assign countInc = setEn && !busy[BusyAddr];
  assign countDec = writeEnB && busy[RDB] && !(setEn && (BusyAddr == RDB));

  // Next busy vector: clear on writeback, then set on issue so that a
  // same-cycle reissue of the register being written back stays pending.
  always_comb begin
    busyNext = busy;
    for (int i = 0; i < Depth; i++) begin
      if (writeEnB && (RDB == AddrWidth'(i))) begin
        busyNext[i] = 1'b0;
      end
      if (setEn && (BusyAddr == AddrWidth'(i))) begin
        busyNext[i] = 1'b1;
      end
    end
  end

  // Next count derived from the transition flags, so it always equals the
  // popcount of the busy vector without needing an adder tree.
  always_comb begin
    countNext = busyCount;
    if (countInc && !countDec) begin
      countNext = busyCount + CountWidth'(1);
    end else if (countDec && !countInc) begin
      countNext = busyCount - CountWidth'(1);
    end
  end

  // Register storage: port B is applied last so it wins on an address tie.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < Depth; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (writeEnA) begin
        regs[RDA] <= WriteDataA;
      end
      if (writeEnB) begin
        regs[RDB] <= WriteDataB;
      end
    end
  end

  // Scoreboard state: busy bits and the matching pending-register count.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      busy      <= '0;
      busyCount <= '0;
    end else begin
      busy      <= busyNext;
      busyCount <= countNext;
    end
  end

  assign BusyCount = busyCount;

  // Address match terms for the two read ports; the zero-register term
  // takes priority over any bypass so address 0 always reads as zero.
  assign rsIsZero = ZeroReg && (RS == '0);
  assign rtIsZero = ZeroReg && (RT == '0);
  assign rsHitB   = RegWriteB && (RDB == RS);
  assign rsHitA   = RegWriteA && (RDA == RS);
  assign rtHitB   = RegWriteB && (RDB == RT);
  assign rtHitA   = RegWriteA && (RDA == RT);

  // RS read data with write-first bypass, port B ahead of port A.
  always_comb begin
    ReadRS = regs[RS];
    if (rsIsZero) begin
      ReadRS = '0;
    end else if (rsHitB) begin
      ReadRS = WriteDataB;
    end else if (rsHitA) begin
      ReadRS = WriteDataA;
    end
  end

  // RT read data with write-first bypass, port B ahead of port A.
  always_comb begin
    ReadRT = regs[RT];
    if (rtIsZero) begin
      ReadRT = '0;
    end else if (rtHitB) begin
      ReadRT = WriteDataB;
    end else if (rtHitA) begin
      ReadRT = WriteDataA;
    end
  end

  // RS operand validity: a writeback landing this cycle resolves the
  // operand immediately; an issue this cycle only takes effect after the edge.
  always_comb begin
    ReadyRS = !busy[RS];
    if (rsIsZero || rsHitB) begin
      ReadyRS = 1'b1;
    end
  end

  // RT operand validity, same rules as the RS port.
  always_comb begin
    ReadyRT = !busy[RT];
    if (rtIsZero || rtHitB) begin
      ReadyRT = 1'b1;
    end
  end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Directed bench for scoreboard_register_file: a table of per-cycle vectors
// on the default instance, then hand sequences for reset, the zero register
// and a wide 32x16 instance.
module tb_scoreboard_register_file;

  typedef struct {
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic        weA;
    logic [2:0]  rda;
    logic [15:0] wda;
    logic        weB;
    logic [2:0]  rdb;
    logic [15:0] wdb;
    logic        sb;
    logic [2:0]  ba;
    logic [15:0] expRS;
    logic        expRdyRS;
    logic [15:0] expRT;
    logic        expRdyRT;
    logic [3:0]  expCount;
  } vectorT;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  rs, rt, rda, rdb, busyAddr;
  logic [15:0] wda, wdb;
  logic        weA, weB, setBusy;

  logic [15:0] readRS, readRT, zReadRS, zReadRT;
  logic        readyRS, readyRT, zReadyRS, zReadyRT;
  logic [3:0]  busyCount, zBusyCount;

  logic [3:0]  wRs, wRt, wRda, wRdb, wBusyAddr;
  logic [31:0] wWda, wWdb, wReadRS, wReadRT;
  logic        wWeA, wWeB, wSetBusy, wReadyRS, wReadyRT;
  logic [4:0]  wBusyCount;

  int checks   = 0;
  int failures = 0;

  vectorT vecs[$];

  scoreboard_register_file #(.DataWidth(16), .AddrWidth(3), .ZeroReg(1'b0)) dut (
    .Clock(Clock), .Reset(Reset), .RS(rs), .RT(rt),
    .ReadRS(readRS), .ReadRT(readRT), .ReadyRS(readyRS), .ReadyRT(readyRT),
    .RDA(rda), .WriteDataA(wda), .RegWriteA(weA),
    .RDB(rdb), .WriteDataB(wdb), .RegWriteB(weB),
    .SetBusy(setBusy), .BusyAddr(busyAddr), .BusyCount(busyCount)
  );

  scoreboard_register_file #(.DataWidth(16), .AddrWidth(3), .ZeroReg(1'b1)) dutZero (
    .Clock(Clock), .Reset(Reset), .RS(rs), .RT(rt),
    .ReadRS(zReadRS), .ReadRT(zReadRT), .ReadyRS(zReadyRS), .ReadyRT(zReadyRT),
    .RDA(rda), .WriteDataA(wda), .RegWriteA(weA),
    .RDB(rdb), .WriteDataB(wdb), .RegWriteB(weB),
    .SetBusy(setBusy), .BusyAddr(busyAddr), .BusyCount(zBusyCount)
  );

  scoreboard_register_file #(.DataWidth(32), .AddrWidth(4), .ZeroReg(1'b0)) dutWide (
    .Clock(Clock), .Reset(Reset), .RS(wRs), .RT(wRt),
    .ReadRS(wReadRS), .ReadRT(wReadRT), .ReadyRS(wReadyRS), .ReadyRT(wReadyRT),
    .RDA(wRda), .WriteDataA(wWda), .RegWriteA(wWeA),
    .RDB(wRdb), .WriteDataB(wWdb), .RegWriteB(wWeB),
    .SetBusy(wSetBusy), .BusyAddr(wBusyAddr), .BusyCount(wBusyCount)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 Clock = ~Clock;

  function automatic vectorT mk(
    input logic [2:0] vRs, input logic [2:0] vRt,
    input logic vWeA, input logic [2:0] vRda, input logic [15:0] vWda,
    input logic vWeB, input logic [2:0] vRdb, input logic [15:0] vWdb,
    input logic vSb, input logic [2:0] vBa,
    input logic [15:0] eRS, input logic eRdyRS,
    input logic [15:0] eRT, input logic eRdyRT, input logic [3:0] eCount);
    vectorT v;
    v.rs = vRs; v.rt = vRt;
    v.weA = vWeA; v.rda = vRda; v.wda = vWda;
    v.weB = vWeB; v.rdb = vRdb; v.wdb = vWdb;
    v.sb = vSb; v.ba = vBa;
    v.expRS = eRS; v.expRdyRS = eRdyRS;
    v.expRT = eRT; v.expRdyRT = eRdyRT; v.expCount = eCount;
    return v;
  endfunction

  task automatic applyStimulus(input vectorT v);
    rs = v.rs; rt = v.rt;
    weA = v.weA; rda = v.rda; wda = v.wda;
    weB = v.weB; rdb = v.rdb; wdb = v.wdb;
    setBusy = v.sb; busyAddr = v.ba;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic idleInputs();
    weA = 1'b0; rda = '0; wda = '0;
    weB = 1'b0; rdb = '0; wdb = '0;
    setBusy = 1'b0; busyAddr = '0;
    wWeA = 1'b0; wRda = '0; wWda = '0;
    wWeB = 1'b0; wRdb = '0; wWdb = '0;
    wSetBusy = 1'b0; wBusyAddr = '0;
  endtask

  initial begin
    logic [2:0] fillOrder [8];
    fillOrder = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd6};

    // rs rt | weA rda wda | weB rdb wdb | sb ba | expRS rdy expRT rdy cnt
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 1, 0));
    vecs.push_back(mk(3, 3, 1, 3, 16'h0005, 0, 0, 16'h0000, 0, 0, 16'h0005, 1, 16'h0005, 1, 0));
    vecs.push_back(mk(3, 2, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0005, 1, 16'h0000, 1, 0));
    vecs.push_back(mk(4, 4, 1, 4, 16'h1111, 1, 4, 16'h2222, 0, 0, 16'h2222, 1, 16'h2222, 1, 0));
    vecs.push_back(mk(4, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h2222, 1, 16'h0005, 1, 0));
    vecs.push_back(mk(5, 5, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 16'h0000, 1, 16'h0000, 1, 0));
    vecs.push_back(mk(5, 4, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h2222, 1, 1));
    vecs.push_back(mk(5, 5, 0, 0, 16'h0000, 1, 5, 16'h00AA, 0, 0, 16'h00AA, 1, 16'h00AA, 1, 1));
    vecs.push_back(mk(5, 5, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h00AA, 1, 16'h00AA, 1, 0));
    vecs.push_back(mk(6, 6, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 6, 16'h0000, 1, 16'h0000, 1, 0));
    vecs.push_back(mk(6, 6, 0, 0, 16'h0000, 1, 6, 16'h0666, 1, 6, 16'h0666, 1, 16'h0666, 1, 1));
    vecs.push_back(mk(6, 6, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0666, 0, 16'h0666, 0, 1));
    vecs.push_back(mk(6, 6, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 6, 16'h0666, 0, 16'h0666, 0, 1));
    vecs.push_back(mk(6, 6, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0666, 0, 16'h0666, 0, 1));
    vecs.push_back(mk(2, 6, 0, 0, 16'h0000, 1, 2, 16'h0222, 0, 0, 16'h0222, 1, 16'h0666, 0, 1));
    vecs.push_back(mk(2, 6, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0222, 1, 16'h0666, 0, 1));
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(6, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, fillOrder[i],
                        16'h0666, 0, 16'h0005, (i < 4) ? 1'b1 : 1'b0, 4'(i + 1)));
    end
    vecs.push_back(mk(6, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0666, 0, 16'h0005, 0, 8));
    vecs.push_back(mk(6, 3, 0, 0, 16'h0000, 1, 3, 16'h0333, 1, 4, 16'h0666, 0, 16'h0333, 1, 8));
    vecs.push_back(mk(6, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0666, 0, 16'h0333, 1, 7));
    vecs.push_back(mk(0, 3, 0, 0, 16'h0000, 1, 0, 16'h0100, 1, 3, 16'h0100, 1, 16'h0333, 1, 7));
    vecs.push_back(mk(0, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0100, 1, 16'h0333, 0, 7));
    vecs.push_back(mk(0, 3, 1, 3, 16'h0AAA, 0, 0, 16'h0000, 0, 0, 16'h0100, 1, 16'h0AAA, 0, 7));
    vecs.push_back(mk(0, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0100, 1, 16'h0AAA, 0, 7));

    rs = '0; rt = '0; wRs = '0; wRt = '0;
    idleInputs();

    // Reset state while held.
    #2;
    checkOutput("resetCount", 32'(busyCount), 32'd0);
    checkOutput("resetReadyRS", 32'(readyRS), 32'd1);
    checkOutput("resetReadRS", 32'(readRS), 32'd0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;

    // Table-driven vectors: outputs sampled before the following edge.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clock);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d.ReadRS", i), 32'(readRS), 32'(vecs[i].expRS));
      checkOutput($sformatf("v%0d.ReadyRS", i), 32'(readyRS), 32'(vecs[i].expRdyRS));
      checkOutput($sformatf("v%0d.ReadRT", i), 32'(readRT), 32'(vecs[i].expRT));
      checkOutput($sformatf("v%0d.ReadyRT", i), 32'(readyRT), 32'(vecs[i].expRdyRT));
      checkOutput($sformatf("v%0d.BusyCount", i), 32'(busyCount), 32'(vecs[i].expCount));
    end

    // Asynchronous reset between edges with many registers busy and written.
    @(negedge Clock);
    idleInputs();
    #1;
    Reset = 1'b1;
    #1;
    checkOutput("midReset.BusyCount", 32'(busyCount), 32'd0);
    for (int a = 0; a < 8; a++) begin
      rs = 3'(a);
      rt = 3'(7 - a);
      #0.1;
      checkOutput($sformatf("midReset.ReadRS%0d", a), 32'(readRS), 32'd0);
      checkOutput($sformatf("midReset.ReadyRS%0d", a), 32'(readyRS), 32'd1);
      checkOutput($sformatf("midReset.ReadyRT%0d", a), 32'(readyRT), 32'd1);
    end
    @(negedge Clock);
    Reset = 1'b0;

    // Zero register: identical stimulus on the ZeroReg=1 and ZeroReg=0 copies.
    @(negedge Clock);
    weA = 1'b1; rda = 3'd0; wda = 16'hFFFF;
    setBusy = 1'b1; busyAddr = 3'd0;
    rs = 3'd0; rt = 3'd0;
    #1;
    checkOutput("zero.bypassRead", 32'(zReadRS), 32'd0);
    checkOutput("zero.bypassReady", 32'(zReadyRS), 32'd1);
    checkOutput("plain.bypassRead", 32'(readRS), 32'h0000FFFF);
    @(negedge Clock);
    idleInputs();
    #1;
    checkOutput("zero.ReadRS", 32'(zReadRS), 32'd0);
    checkOutput("zero.ReadyRS", 32'(zReadyRS), 32'd1);
    checkOutput("zero.BusyCount", 32'(zBusyCount), 32'd0);
    checkOutput("plain.ReadRS", 32'(readRS), 32'h0000FFFF);
    checkOutput("plain.ReadyRS", 32'(readyRS), 32'd0);
    checkOutput("plain.BusyCount", 32'(busyCount), 32'd1);

    // Wide instance: write and busy on the top address.
    @(negedge Clock);
    wWeA = 1'b1; wRda = 4'd15; wWda = 32'h0000_0005;
    wRs = 4'd15; wRt = 4'd14;
    #1;
    checkOutput("wide.bypassRead", wReadRS, 32'h0000_0005);
    checkOutput("wide.bypassReady", 32'(wReadyRS), 32'd1);
    @(negedge Clock);
    idleInputs();
    wSetBusy = 1'b1; wBusyAddr = 4'd15;
    #1;
    checkOutput("wide.ReadRS", wReadRS, 32'h0000_0005);
    checkOutput("wide.ReadRT", wReadRT, 32'd0);
    checkOutput("wide.countBefore", 32'(wBusyCount), 32'd0);
    @(negedge Clock);
    idleInputs();
    #1;
    checkOutput("wide.ReadyRS", 32'(wReadyRS), 32'd0);
    checkOutput("wide.BusyCount", 32'(wBusyCount), 32'd1);
    checkOutput("wide.ReadyRT", 32'(wReadyRT), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
